// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle for the command master.
// The master drives addresses, data and valids; the slave drives readies and responses.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a command/response port.
// A wait-state counter pulses timeout_o once when a slave stalls too long.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_write_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic                    timeout_o,
  output logic                    busy_o,
  axi_lite_cmd_master_if.master   m_axi
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_B, RD_AR, RD_R, RSP
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_PRE  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          waiting;
  logic          adv;

  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign busy_o       = (state != IDLE);

  // Wait-state flag and the condition that lets the FSM leave it
  always_comb begin
    adv     = 1'b0;
    waiting = 1'b1;
    unique case (state)
      WR:      adv = (!m_axi.awvalid || m_axi.awready) &&
                     (!m_axi.wvalid  || m_axi.wready);
      WR_B:    adv = m_axi.bvalid;
      RD_AR:   adv = m_axi.arready;
      RD_R:    adv = m_axi.rvalid;
      default: waiting = 1'b0;
    endcase
  end

  // Stall counter: clears on state change, saturates at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      timeout_o <= 1'b0;
    end else if (!waiting || adv) begin
      tcnt      <= '0;
      timeout_o <= 1'b0;
    end else if (TIMEOUT != 0 && tcnt != TO_LAST) begin
      tcnt      <= tcnt + CW'(1);
      timeout_o <= (tcnt == TO_PRE);
    end else begin
      timeout_o <= 1'b0;
    end
  end

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_write_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_resp_o    <= 2'b00;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            if (cmd_write_i) begin
              m_axi.awaddr  <= cmd_addr_i;
              m_axi.wdata   <= cmd_wdata_i;
              m_axi.wstrb   <= cmd_wstrb_i;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi.araddr  <= cmd_addr_i;
              m_axi.arvalid <= 1'b1;
              state         <= RD_AR;
            end
          end
        end
        WR: begin
          if (m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
          if (adv) begin
            m_axi.bready <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (adv) begin
            m_axi.bready <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_write_o  <= 1'b1;
            rsp_rdata_o  <= '0;
            rsp_resp_o   <= m_axi.bresp;
            state        <= RSP;
          end
        end
        RD_AR: begin
          if (adv) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= RD_R;
          end
        end
        RD_R: begin
          if (adv) begin
            m_axi.rready <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_write_o  <= 1'b0;
            rsp_rdata_o  <= m_axi.rdata;
            rsp_resp_o   <= m_axi.rresp;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI4-Lite initiator that drives the s0_axi slave port of the flocra core.
- Used by the Verilator top-level model and by FPGA-side test sequencers.
- Accepts single read/write commands on a valid/ready command port, runs the full AXI4-Lite handshake, and returns the response on a valid/ready response port.
- One transaction in flight at a time; a timeout counter flags stalled slaves.

Parameters:
ADDR_WIDTH, 19, AXI address width (matches flocra C_S0_AXI_ADDR_WIDTH)
DATA_WIDTH, 32, AXI data width; only 32 supported
TIMEOUT, 1023, cycles waited in any AXI wait state before timeout_o pulses; 0 disables

Ports:
clk  in  1  system clock; also drives the AXI bus
rst_n  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_WIDTH  byte address
cmd_wdata_i  in  DATA_WIDTH  write data
cmd_wstrb_i  in  DATA_WIDTH/8  write strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_write_o  out  1  response belongs to a write
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes)
rsp_resp_o  out  2  BRESP or RRESP
timeout_o  out  1  one-cycle pulse when TIMEOUT is reached
busy_o  out  1  high when not IDLE
m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel; awprot tied 3'b000
m_axi_awready  in  1
m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel; arprot tied 3'b000
m_axi_arready  in  1
m_axi_rdata  in  DATA_WIDTH
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE.
  - Every registered output is 0 except cmd_ready_o = 1.
  - AXI valids, bready and rready are 0; address and data buses are 0.
- Command capture: the command is captured into internal registers on cmd_valid_i & cmd_ready_o. cmd_ready_o is high only in IDLE.
- States: IDLE, WR (AW/W issue), WR_B, RD_AR, RD_R, RSP.
- IDLE, write command accepted at edge N:
  - m_axi_awvalid and m_axi_wvalid assert from cycle N+1.
  - Next state WR.
- WR:
  - Each valid drops the cycle after its own ready handshake; the two channels complete independently, in either order or in the same cycle.
  - When both have completed, go to WR_B with m_axi_bready = 1.
- WR_B: on bvalid, latch bresp and go to RSP with rsp_write_o = 1 and rsp_rdata_o = 0. bready deasserts in the same edge.
- IDLE, read command accepted:
  - m_axi_arvalid asserts next cycle; state RD_AR.
  - On arready, go to RD_R: arvalid drops and rready = 1.
  - On rvalid, latch rdata/rresp and go to RSP with rsp_write_o = 0.
- RSP:
  - rsp_valid_o = 1 and all response fields stay stable until rsp_ready_i.
  - Then return to IDLE, where cmd_ready_o = 1.
  - A new command cannot be accepted in the same cycle as the response handshake.
  - Minimum command-to-command spacing is 4 cycles for a zero-wait slave.
- AXI rules:
  - No valid deasserts before its handshake; addr/data/strb stay stable while their valid is high.
  - ready/valid inputs are sampled only in the relevant state; a spurious bvalid/rvalid elsewhere is ignored.
- Timeout:
  - A counter clears on every state entry and increments in WR, WR_B, RD_AR and RD_R.
  - When it equals TIMEOUT (nonzero), timeout_o pulses for 1 cycle and the counter saturates.
  - The FSM keeps waiting; the AXI protocol is never violated.
  - The counter is not active in RSP.
- Reset mid-transaction: all valids drop immediately (asynchronous) and the state returns to IDLE. The slave is reset alongside by the same rst_n.
- rsp_resp_o is passed through unmodified (OKAY = 2'b00, SLVERR = 2'b10).

Test Plan:
- Write 0x0001_2345 to 0x40, strb 4'hF, zero-wait slave:
  - awvalid and wvalid rise 1 cycle after the cmd handshake.
  - bready follows; rsp_valid_o appears with write=1, resp=00.
  - Total spacing 4 cycles.
- Slave asserts wready 3 cycles before awready:
  - wvalid drops after its handshake; awvalid is held until its own.
  - Single response, no duplicate write.
- Read 0x80 with slave returning rdata=0xDEADBEEF, rresp=2'b10 after 5 wait cycles:
  - rsp_rdata_o = 0xDEADBEEF, rsp_resp_o = 2'b10, write=0.
- rsp_ready_i held low for 10 cycles:
  - rsp fields are stable and cmd_ready_o stays 0.
  - A pending command is accepted the cycle after the rsp handshake.
- TIMEOUT=8, slave never asserts arready:
  - timeout_o pulses exactly once, 8 cycles after RD_AR entry.
  - arvalid stays high.
- rst_n asserted during WR_B: all AXI valids, bready and rsp_valid_o go to 0 asynchronously, and cmd_ready_o = 1 after release.
